code_entry_ctrl: RTL and testbench

Sequencing controller for the microwave's 4-digit BCD access-code comparator. Collects keypad digits into a 16-bit entry register, triggers a registered compare against the stored code, and tracks failed attempts with a timed lockout. Once unlocked, it also lets the user program a new code. It sits between the keypad debouncer/decoder and the door/start-enable logic.

---
 rtl/code_entry_pkg.sv | 11 +
 rtl/code_entry_ctrl_match.sv | 12 +
 rtl/code_entry_ctrl.sv | 131 +++++++++++++
 tb/tb_code_entry_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/code_entry_pkg.sv
// code_entry_pkg: shared state type, widths, reset code and BCD check for the access-code controller
package code_entry_pkg;
    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT} state_t;
    localparam int DIGIT_W = 4;
    localparam int DEF_DIGITS = 4;
    localparam int CODE_W = DIGIT_W * DEF_DIGITS;
    localparam logic [CODE_W-1:0] DEF_RESET_CODE = 16'h1234;
    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction
endpackage

// File: rtl/code_entry_ctrl_match.sv
// code_match: combinational equality of the entered code against the stored code
module code_match
    import code_entry_pkg::*;
#(
    parameter int W = CODE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         match
);
    assign match = &(~(a ^ b));
endmodule

// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: keypad code entry, registered compare, failed-attempt lockout and code programming
module code_entry_ctrl
    import code_entry_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int MAX_TRIES = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter logic [DIGIT_W*DIGITS-1:0] RESET_CODE = DEF_RESET_CODE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               enter,
    input  logic               clear,
    input  logic               prog_en,
    output logic               granted,
    output logic               fail,
    output logic               prog_done,
    output logic               unlocked,
    output logic               locked,
    output logic [2:0]         digit_count
);
    localparam int CW = DIGIT_W * DIGITS;
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int NW = $clog2((LOCK_CYCLES > TIMEOUT_CYCLES ? LOCK_CYCLES : TIMEOUT_CYCLES) + 1);
    state_t          state, state_n;
    logic [CW-1:0]   entry, entry_n, code_q, code_n, shifted;
    logic [2:0]      count_n;
    logic [TW-1:0]   tries, tries_n;
    logic [NW-1:0]   cnt, cnt_n;
    logic            granted_n, fail_n, prog_n, match, full, take;
    code_match #(.W(CW)) u_match (.a(entry), .b(code_q), .match(match));
    assign full = digit_count == 3'(DIGITS);
    assign take = digit_valid && bcd_valid(digit) && !full;
    assign shifted = {entry[CW-DIGIT_W-1:0], digit};
    always_comb begin
        state_n = state;
        entry_n = entry;
        count_n = digit_count;
        tries_n = tries;
        cnt_n = cnt;
        code_n = code_q;
        granted_n = 1'b0;
        fail_n = 1'b0;
        prog_n = 1'b0;
        case (state)
            IDLE: if (!clear && !enter && take) begin
                entry_n = shifted;
                count_n = digit_count + 3'd1;
                cnt_n = '0;
                state_n = ENTRY;
            end
            ENTRY: if (clear) begin
                entry_n = '0;
                count_n = '0;
                state_n = IDLE;
            end else if (enter) begin
                state_n = CHECK;
            end else if (take) begin
                entry_n = shifted;
                count_n = digit_count + 3'd1;
                cnt_n = '0;
            end else if (cnt == NW'(TIMEOUT_CYCLES - 1)) begin
                entry_n = '0;
                count_n = '0;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            CHECK: begin
                entry_n = '0;
                count_n = '0;
                cnt_n = '0;
                granted_n = match && full;
                fail_n = !(match && full);
                tries_n = granted_n ? '0 : tries + 1'b1;
                state_n = granted_n ? UNLOCKED : (tries_n == TW'(MAX_TRIES) ? LOCKOUT : IDLE);
            end
            UNLOCKED: if (clear) begin
                entry_n = '0;
                count_n = '0;
                state_n = IDLE;
            end else if (enter) begin
                entry_n = '0;
                count_n = '0;
                prog_n = prog_en && full;
                code_n = prog_n ? entry : code_q;
            end else if (take) begin
                entry_n = shifted;
                count_n = digit_count + 3'd1;
            end
            LOCKOUT: if (cnt == NW'(LOCK_CYCLES - 1)) begin
                cnt_n = '0;
                tries_n = '0;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            entry <= '0;
            digit_count <= '0;
            tries <= '0;
            cnt <= '0;
            code_q <= RESET_CODE;
            granted <= 1'b0;
            fail <= 1'b0;
            prog_done <= 1'b0;
            unlocked <= 1'b0;
            locked <= 1'b0;
        end else begin
            state <= state_n;
            entry <= entry_n;
            digit_count <= count_n;
            tries <= tries_n;
            cnt <= cnt_n;
            code_q <= code_n;
            granted <= granted_n;
            fail <= fail_n;
            prog_done <= prog_n;
            unlocked <= state_n == UNLOCKED;
            locked <= state_n == LOCKOUT;
        end
    end
endmodule

// File: tb/tb_code_entry_ctrl.sv
// tb_code_entry_ctrl: scoreboard bench with a digit-queue reference model of the access-code controller
module tb_code_entry_ctrl;
    localparam int DIG = 4;
    localparam int LOCK = 8;
    localparam int TMO = 16;
    localparam int TRIES = 3;
    logic clk = 1'b0, rst_n = 1'b0, digit_valid = 1'b0, enter = 1'b0, clear = 1'b0, prog_en = 1'b0;
    logic [3:0] digit = '0;
    logic granted, fail, prog_done, unlocked, locked;
    logic [2:0] digit_count;
    code_entry_ctrl #(.LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit), .enter(enter),
        .clear(clear), .prog_en(prog_en), .granted(granted), .fail(fail), .prog_done(prog_done),
        .unlocked(unlocked), .locked(locked), .digit_count(digit_count)
    );
    always #5 clk = ~clk;
    typedef struct {int kind; int at;} ev_t;
    ev_t exp_q[$];
    int checks = 0, errors = 0, cyc = 0;
    int ent[$];
    logic [15:0] m_code = 16'h1234;
    int m_tries = 0;
    bit m_unl = 0, m_lck = 0;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction
    // Pulse kinds: 4 granted, 2 fail, 1 prog_done; each must arrive in order at its predicted cycle
    always @(negedge clk) begin
        if (rst_n && (granted || fail || prog_done)) begin
            ev_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected pulse got=%b want=none (cycle %0d)", {granted, fail, prog_done}, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse kind", int'({granted, fail, prog_done}), e.kind);
                chk("pulse cycle", cyc, e.at);
            end
        end
    end
    function automatic logic [15:0] ent_val();
        logic [15:0] v = '0;
        foreach (ent[i]) v = {v[11:0], 4'(ent[i])};
        return v;
    endfunction
    task automatic press(input int d);
        digit_valid = 1'b1;
        digit = 4'(d);
        if (!m_lck && d <= 9 && ent.size() < DIG) ent.push_back(d);
        @(negedge clk);
        digit_valid = 1'b0;
        chk("digit_count", int'(digit_count), ent.size());
    endtask
    task automatic do_enter();
        int c = cyc;
        ev_t e;
        if (m_unl) begin
            if (prog_en && ent.size() == DIG) begin
                m_code = ent_val();
                e.kind = 1; e.at = c + 1; exp_q.push_back(e);
            end
        end else if (!m_lck && ent.size() > 0) begin
            e.at = c + 2;
            if (ent.size() == DIG && ent_val() == m_code) begin
                e.kind = 4; m_unl = 1; m_tries = 0;
            end else begin
                e.kind = 2; m_tries++;
                if (m_tries == TRIES) m_lck = 1;
            end
            exp_q.push_back(e);
        end
        ent.delete();
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        chk("unlocked", int'(unlocked), int'(m_unl));
        chk("locked", int'(locked), int'(m_lck));
        chk("digit_count after enter", int'(digit_count), 0);
    endtask
    task automatic do_clear(input bit with_enter);
        clear = 1'b1;
        enter = with_enter;
        digit_valid = with_enter;
        digit = 4'd7;
        ent.delete();
        m_unl = 0;
        @(negedge clk);
        clear = 1'b0; enter = 1'b0; digit_valid = 1'b0;
        @(negedge clk);
        chk("unlocked after clear", int'(unlocked), 0);
        chk("digit_count after clear", int'(digit_count), 0);
    endtask
    task automatic lockout_wait();
        int n = 0;
        while (locked && n < 50) begin
            n++;
            digit_valid = 1'b1;
            digit = 4'($urandom_range(0, 9));
            enter = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        digit_valid = 1'b0;
        enter = 1'b0;
        chk("lockout length", n, LOCK);
        chk("digit_count after lockout", int'(digit_count), 0);
        m_lck = 0;
        m_tries = 0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset locked", int'(locked), 0);
        chk("reset unlocked", int'(unlocked), 0);
        chk("reset digit_count", int'(digit_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        ent.delete();
        m_code = 16'h1234; m_tries = 0; m_unl = 0; m_lck = 0;
    endtask
    task automatic enter_code(input logic [15:0] v);
        for (int i = 0; i < DIG; i++) press(int'(v[15-4*i -: 4]));
        do_enter();
    endtask
    initial begin
        #1;
        chk("reset granted", int'(granted), 0);
        chk("reset fail", int'(fail), 0);
        chk("reset prog_done", int'(prog_done), 0);
        chk("reset unlocked", int'(unlocked), 0);
        chk("reset locked", int'(locked), 0);
        chk("reset digit_count", int'(digit_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enter_code(16'h1234);
        do_clear(0);
        repeat (3) enter_code(16'h1235);
        lockout_wait();
        enter_code(16'h1234);
        prog_en = 1'b1;
        enter_code(16'h9876);
        prog_en = 1'b0;
        do_clear(0);
        enter_code(16'h1234);
        enter_code(16'h9876);
        do_clear(0);
        for (int i = 0; i < 3; i++) press(i + 1);
        do_enter();
        for (int i = 0; i < DIG; i++) press(int'(m_code[15-4*i -: 4]));
        press(5);
        press(10);
        do_enter();
        do_clear(0);
        press(4'hA);
        press(4'hF);
        press(1); press(1);
        do_enter();
        press(2); press(3);
        repeat (TMO - 1) @(negedge clk);
        chk("digit_count before timeout", int'(digit_count), 2);
        @(negedge clk);
        ent.delete();
        chk("digit_count after timeout", int'(digit_count), 0);
        enter_code(16'h0000);
        enter_code(16'h0001);
        if (m_lck) lockout_wait();
        for (int i = 0; i < DIG; i++) press(int'(m_code[15-4*i -: 4]));
        do_clear(1);
        repeat (3) enter_code(16'h5555);
        repeat (3) @(negedge clk);
        do_reset();
        enter_code(16'h4321);
        enter_code(16'h4322);
        enter_code(16'h1234);
        do_clear(0);
        repeat (40) begin
            int n = $urandom_range(2, 5);
            bit good = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++)
                press(good && i < DIG ? int'(m_code[15-4*i -: 4]) : $urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) do_clear(1'($urandom_range(0, 1)));
            else do_enter();
            if (m_lck) lockout_wait();
            if (m_unl) begin
                prog_en = 1'($urandom_range(0, 1));
                for (int i = 0; i < $urandom_range(3, 5); i++) press($urandom_range(0, 9));
                do_enter();
                prog_en = 1'b0;
                do_clear(0);
            end
        end
        repeat (5) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
